// File: rtl/criq_tag_recycler.sv
// In-order tag recycler: tracks allocated CRIQ tags, collects out-of-order
// completions and pushes retired tags back into the free-tag queue in order.
module criq_tag_recycler #(
    parameter int unsigned TAGWIDE = 5,
    parameter int unsigned TAGDEEP = 8
) (
    input  logic               Clk,
    input  logic               Rest,
    input  logic               AllocValid,
    input  logic [TAGWIDE-1:0] AllocTag,
    output logic               AllocReady,
    input  logic               DoneValid,
    input  logic [TAGWIDE-1:0] DoneTag,
    input  logic               FlushReq,
    input  logic               FreeFull,
    output logic               FreeWable,
    output logic [TAGWIDE-1:0] FreeDin,
    output logic               FreeClean,
    output logic [3:0]         InFlightCnt,
    output logic               Empty
);

    localparam int unsigned PTRW = (TAGDEEP > 1) ? $clog2(TAGDEEP) : 1;

    logic [TAGWIDE-1:0] tag_q [TAGDEEP];
    logic [TAGDEEP-1:0] done_q, done_d;
    logic [TAGDEEP-1:0] valid_c, match_c;
    logic [PTRW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [3:0]         count_q, count_d;
    logic               free_wable_q, free_wable_d;
    logic [TAGWIDE-1:0] free_din_q, free_din_d;
    logic               free_clean_q, free_clean_d;
    logic               alloc_fire_c, done_fire_c, retire_fire_c;

    // An entry is live when its distance from head is below the count.
    for (genvar i = 0; i < TAGDEEP; i++) begin : g_entry
        assign valid_c[i] = 4'(PTRW'(PTRW'(i) - head_q)) < count_q;
        assign match_c[i] = valid_c[i] && (tag_q[i] == DoneTag);
    end

    assign AllocReady    = count_q < 4'(TAGDEEP);
    assign alloc_fire_c  = AllocValid && AllocReady && !FlushReq;
    assign done_fire_c   = DoneValid && !FlushReq;
    assign retire_fire_c = (count_q != 4'd0) && done_q[head_q] && !FreeFull && !FlushReq;

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        done_d       = done_q;
        free_wable_d = 1'b0;
        free_din_d   = free_din_q;
        free_clean_d = 1'b0;
        if (FlushReq) begin
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            done_d       = '0;
            free_clean_d = 1'b1;
        end else begin
            if (done_fire_c) begin
                done_d = done_q | match_c;
            end
            if (retire_fire_c) begin
                done_d[head_q] = 1'b0;
                head_d         = head_q + PTRW'(1);
                free_wable_d   = 1'b1;
                free_din_d     = tag_q[head_q];
            end
            if (alloc_fire_c) begin
                done_d[tail_q] = 1'b0;
                tail_d         = tail_q + PTRW'(1);
            end
            case ({alloc_fire_c, retire_fire_c})
                2'b10:   count_d = count_q + 4'd1;
                2'b01:   count_d = count_q - 4'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rest) begin
        if (!Rest) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            done_q       <= '0;
            free_wable_q <= 1'b0;
            free_din_q   <= '0;
            free_clean_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            done_q       <= done_d;
            free_wable_q <= free_wable_d;
            free_din_q   <= free_din_d;
            free_clean_q <= free_clean_d;
        end
    end

    // Tag payloads need no reset; liveness is tracked by head/count.
    always_ff @(posedge Clk) begin
        if (alloc_fire_c) begin
            tag_q[tail_q] <= AllocTag;
        end
    end

    assign FreeWable   = free_wable_q;
    assign FreeDin     = free_din_q;
    assign FreeClean   = free_clean_q;
    assign InFlightCnt = count_q;
    assign Empty       = (count_q == 4'd0);

endmodule
